ft2_spi_cmd_sequencer: RTL and testbench

//  Command sequencer between the FT2 receive FIFO and the front-end SPI transmitter.

---
 rtl/ft2_spi_cmd_sequencer_pkg.sv | 23 ++
 rtl/ft2_spi_cmd_sequencer_if.sv | 30 +++
 rtl/ft2_spi_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_ft2_spi_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft2_spi_cmd_sequencer_pkg.sv
// ft2_spi_pkg: shared definitions for the FT2 -> SPI command sequencer.
//   state_e   : sequencer FSM states
//   ST_*      : status codes returned to the host over the FT2 write path
//   CTRL_SYNC : required value of the control-byte sync field [7:3]
package ft2_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_CHK,
    XFER_WAIT,
    XFER_LOAD,
    XFER,
    STATUS
  } state_e;

  localparam logic [7:0] ST_OK     = 8'h24;  // '$'
  localparam logic [7:0] ST_BADCTL = 8'h3F;  // '?'
  localparam logic [7:0] ST_FULL   = 8'h66;  // 'f'
  localparam logic [7:0] ST_TMO    = 8'h74;  // 't'

  localparam logic [4:0] CTRL_SYNC = 5'b11111;

endpackage

// File: rtl/ft2_spi_cmd_sequencer_if.sv
// ft2_spi_cmd_sequencer_if: bundles the RX FIFO, SPI transmitter and FT2
// status-write signals seen by the command sequencer.
//   master : sequencer side (drives fifo_rd_en, fifo_rst, spi_*, status_*, busy)
//   slave  : environment side (drives fifo_*, spi_done, status_sent)
interface ft2_spi_cmd_sequencer_if;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       fifo_rst;
  logic [7:0] spi_data;
  logic       spi_start;
  logic       spi_done;
  logic [7:0] status_byte;
  logic       status_wr_en;
  logic       status_sent;
  logic       busy;

  modport master (
    input  fifo_empty, fifo_full, fifo_rd_data, spi_done, status_sent,
    output fifo_rd_en, fifo_rst, spi_data, spi_start, status_byte,
           status_wr_en, busy
  );

  modport slave (
    output fifo_empty, fifo_full, fifo_rd_data, spi_done, status_sent,
    input  fifo_rd_en, fifo_rst, spi_data, spi_start, status_byte,
           status_wr_en, busy
  );
endinterface

// File: rtl/ft2_spi_cmd_sequencer.sv
// ft2_spi_cmd_sequencer: pops a control byte from the FT2 RX FIFO, validates
// it, streams len+1 payload bytes to the SPI transmitter one at a time and
// reports a one-byte status to the host. Flushes the FIFO on a bad control
// byte or on overflow.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : FIFO / SPI / status signals (ft2_spi_cmd_sequencer_if.master)
//
// Optional feature: define FT2_SPI_TIMEOUT_EN to abort a frame that stalls in
// XFER_WAIT for TIMEOUT_CYC cycles (status 't'). Without it XFER_WAIT waits
// forever and the TIMEOUT_CYC parameter does not exist.
//
// state     | meaning
// IDLE      | waiting for a control byte in the FIFO
// CTRL_CHK  | popped control byte on fifo_rd_data, check sync field
// XFER_WAIT | waiting for the next payload byte
// XFER_LOAD | popped payload byte on fifo_rd_data, latch it for SPI
// XFER      | SPI shifting, waiting for spi_done
// STATUS    | presenting status_byte until status_sent
module ft2_spi_cmd_sequencer
  import ft2_spi_pkg::*;
#(
  parameter int LEN_W = 3
`ifdef FT2_SPI_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 50000
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ft2_spi_cmd_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       spi_data_q, spi_data_d;
  logic [7:0]       status_q, status_d;
  logic             spi_start_q, spi_start_d;
  logic             rd_en;
  logic             flush;
  logic             overflow;

`ifdef FT2_SPI_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign tmo_d   = (state_q == XFER_WAIT) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // Overflow is only acted on while a frame is in flight; in STATUS the
  // FIFO has already been flushed and the host is being answered.
  assign overflow = bus.fifo_full && (state_q != IDLE) && (state_q != STATUS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    spi_data_d  = spi_data_q;
    status_d    = status_q;
    spi_start_d = 1'b0;
    rd_en       = 1'b0;
    flush       = 1'b0;

    if (overflow) begin
      status_d = ST_FULL;
      flush    = 1'b1;
      state_d  = STATUS;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.fifo_empty) begin
            rd_en   = 1'b1;
            state_d = CTRL_CHK;
          end
        end
        CTRL_CHK: begin
          if (bus.fifo_rd_data[7:LEN_W] == CTRL_SYNC) begin
            cnt_d   = bus.fifo_rd_data[LEN_W-1:0];
            state_d = XFER_WAIT;
          end else begin
            status_d = ST_BADCTL;
            flush    = 1'b1;
            state_d  = STATUS;
          end
        end
        XFER_WAIT: begin
`ifdef FT2_SPI_TIMEOUT_EN
          if (tmo_hit) begin
            status_d = ST_TMO;
            flush    = 1'b1;
            state_d  = STATUS;
          end else
`endif
          if (!bus.fifo_empty) begin
            rd_en   = 1'b1;
            state_d = XFER_LOAD;
          end
        end
        XFER_LOAD: begin
          // spi_start is registered so it rises together with spi_data.
          spi_data_d  = bus.fifo_rd_data;
          spi_start_d = 1'b1;
          state_d     = XFER;
        end
        XFER: begin
          if (bus.spi_done) begin
            if (cnt_q == '0) begin
              status_d = ST_OK;
              state_d  = STATUS;
            end else begin
              cnt_d   = cnt_q - 1'b1;
              state_d = XFER_WAIT;
            end
          end
        end
        STATUS: begin
          if (bus.status_sent) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      spi_data_q  <= '0;
      status_q    <= '0;
      spi_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spi_data_q  <= spi_data_d;
      status_q    <= status_d;
      spi_start_q <= spi_start_d;
    end
  end

  // The IDLE pop depends only on fifo_empty, so gate it with reset to keep
  // the FIFO untouched while the block is held in reset.
  assign bus.fifo_rd_en   = rd_en & rst_n;
  assign bus.fifo_rst     = flush;
  assign bus.spi_data     = spi_data_q;
  assign bus.spi_start    = spi_start_q;
  assign bus.status_byte  = status_q;
  assign bus.status_wr_en = (state_q == STATUS);
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ft2_spi_cmd_sequencer.sv
module tb_ft2_spi_cmd_sequencer;

  typedef struct packed {
    logic       is_st;
    logic [7:0] val;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft2_spi_cmd_sequencer_if bus_if();

`ifdef FT2_SPI_TIMEOUT_EN
  ft2_spi_cmd_sequencer #(.TIMEOUT_CYC(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
`else
  ft2_spi_cmd_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
`endif

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int checks = 0, passed = 0;
  int cyc = 0, rst_cnt = 0, exp_rst = 0, viol = 0;
  int spi_seen = 0, done_cyc = 0, stat_cyc = 0;
  bit spi_auto = 1'b1, full_req = 1'b0, p_done = 1'b0, p_sent = 1'b0;
  logic [7:0] p_data = 8'h00;
  int spi_cnt = -1, stat_delay = 2, ph = 0, st_cnt = 0;
  logic [7:0] st_byte;
  bit held_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Input driver: inputs change only just after the active edge.
  always @(posedge clk) begin
    #1;
    bus_if.fifo_empty   = (fifo_q.size() == 0);
    bus_if.fifo_rd_data = p_data;
    bus_if.spi_done     = p_done;
    p_done              = 1'b0;
    bus_if.status_sent  = p_sent;
    p_sent              = 1'b0;
    bus_if.fifo_full    = full_req;
  end

  // Environment models + scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (bus_if.fifo_rd_en && bus_if.fifo_rst) viol++;
      if (bus_if.fifo_rd_en) begin
        if (fifo_q.size() != 0) p_data = fifo_q.pop_front();
        else viol++;
      end
      if (bus_if.fifo_rst) begin
        rst_cnt++;
        fifo_q.delete();
      end
      if (bus_if.spi_done) done_cyc = cyc;
      if (spi_cnt == 0) begin
        p_done  = 1'b1;
        spi_cnt = -1;
      end else if (spi_cnt > 0) spi_cnt--;
      if (bus_if.spi_start) begin
        spi_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spi_extra: spi_data %0h with nothing expected", bus_if.spi_data);
        end else begin
          e = exp_q.pop_front();
          check("spi_data", {1'b0, bus_if.spi_data}, {e.is_st, e.val});
        end
        if (spi_auto) spi_cnt = $urandom_range(0, 3);
      end
      if (ph == 3) begin
        check("status_drop", bus_if.status_wr_en, 0);
        ph = 0;
      end else if (ph == 2) ph = 3;
      if (ph == 0 && bus_if.status_wr_en) begin
        ph       = 1;
        st_cnt   = stat_delay;
        st_byte  = bus_if.status_byte;
        held_bad = 1'b0;
        stat_cyc = cyc;
      end
      if (ph == 1) begin
        if (!bus_if.status_wr_en || bus_if.status_byte !== st_byte) held_bad = 1'b1;
        if (st_cnt == 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL status_extra: status %0h with nothing expected", bus_if.status_byte);
          end else begin
            e = exp_q.pop_front();
            check("status", {1'b1, bus_if.status_byte}, {e.is_st, e.val});
          end
          check("status_held", held_bad, 0);
          p_sent = 1'b1;
          ph     = 2;
        end else st_cnt--;
      end
    end
  end

  // Reference model: frame -> expected SPI bytes and status.
  task automatic model_frame(input bq_t b);
    exp_t e;
    int len;
    if (b[0][7:3] == 5'b11111) begin
      len = int'(b[0][2:0]) + 1;
      for (int i = 1; i <= len; i++) begin
        e = '{is_st: 1'b0, val: b[i]};
        exp_q.push_back(e);
      end
      e = '{is_st: 1'b1, val: 8'h24};
      exp_q.push_back(e);
    end else begin
      e = '{is_st: 1'b1, val: 8'h3F};
      exp_q.push_back(e);
      exp_rst++;
    end
  endtask

  task automatic push_bytes(input bq_t b, input int max_gap);
    foreach (b[i]) begin
      @(negedge clk);
      fifo_q.push_back(b[i]);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus_if.busy || ph != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 3000), 1);
    check("flush_count", rst_cnt, exp_rst);
  endtask

  task automatic wait_spi(input int prev);
    int n = 0;
    while (spi_seen == prev && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("spi_start_seen", (n < 500), 1);
  endtask

  task automatic send_frame(input bq_t b, input string name);
    model_frame(b);
    push_bytes(b, 2);
    wait_idle(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t  b;
    exp_t e;
    int   n, prev, len;
    bus_if.fifo_empty   = 1'b1;
    bus_if.fifo_full    = 1'b0;
    bus_if.fifo_rd_data = 8'h00;
    bus_if.spi_done     = 1'b0;
    bus_if.status_sent  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus_if.busy, 0);
    check("rst_spi_start", bus_if.spi_start, 0);
    check("rst_spi_data", bus_if.spi_data, 0);
    check("rst_status_wr_en", bus_if.status_wr_en, 0);
    check("rst_status_byte", bus_if.status_byte, 0);
    check("rst_fifo_rd_en", bus_if.fifo_rd_en, 0);
    check("rst_fifo_rst", bus_if.fifo_rst, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-byte frame.
    b = '{8'hF9, 8'hA1, 8'hB2};
    send_frame(b, "frame_len1");
    check("busy_after_ok", bus_if.busy, 0);

    // Bad control byte.
    b = '{8'h55};
    send_frame(b, "frame_badctl");

    // Maximum length frame with slow status acceptance.
    stat_delay = 7;
    b = '{8'hFF};
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    send_frame(b, "frame_len8");

    // Random frames.
    for (int f = 0; f < 15; f++) begin
      stat_delay = $urandom_range(0, 4);
      b.delete();
      if ($urandom_range(0, 4) != 0) begin
        len = $urandom_range(0, 7);
        b.push_back({5'b11111, 3'(len)});
        for (int i = 0; i <= len; i++) b.push_back(8'($urandom));
      end else begin
        b.push_back(8'($urandom_range(0, 247)));
      end
      send_frame(b, "frame_random");
    end

    // Overflow mid-byte, then a late spi_done while in STATUS.
    stat_delay = 6;
    spi_auto   = 1'b0;
    e = '{is_st: 1'b0, val: 8'hA5}; exp_q.push_back(e);
    e = '{is_st: 1'b1, val: 8'h66}; exp_q.push_back(e);
    exp_rst++;
    prev = spi_seen;
    b = '{8'hF8, 8'hA5};
    push_bytes(b, 0);
    wait_spi(prev);
    full_req = 1'b1;
    n = rst_cnt;
    for (int i = 0; i < 100 && rst_cnt == n; i++) @(negedge clk);
    full_req = 1'b0;
    for (int i = 0; i < 100 && ph == 0; i++) @(negedge clk);
    p_done = 1'b1;
    wait_idle("frame_overflow");
    spi_auto = 1'b1;

    // Reset in the middle of a byte transfer.
    stat_delay = 2;
    spi_auto   = 1'b0;
    b = '{8'hF9, 8'h11, 8'h22};
    model_frame(b);
    prev = spi_seen;
    push_bytes(b, 0);
    wait_spi(prev);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus_if.busy, 0);
    check("mid_rst_status_byte", bus_if.status_byte, 0);
    check("mid_rst_spi_data", bus_if.spi_data, 0);
    check("mid_rst_fifo_rd_en", bus_if.fifo_rd_en, 0);
    check("mid_rst_status_wr_en", bus_if.status_wr_en, 0);
    exp_q.delete();
    fifo_q.delete();
    spi_cnt = -1;
    ph      = 0;
    p_done  = 1'b0;
    p_sent  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    spi_auto = 1'b1;
    b = '{8'hF9, 8'h33, 8'h44};
    send_frame(b, "frame_after_rst");

`ifdef FT2_SPI_TIMEOUT_EN
    // Payload stalls after the first byte.
    stat_delay = 1;
    e = '{is_st: 1'b0, val: 8'hA1}; exp_q.push_back(e);
    e = '{is_st: 1'b1, val: 8'h74}; exp_q.push_back(e);
    exp_rst++;
    b = '{8'hF9, 8'hA1};
    push_bytes(b, 0);
    wait_idle("frame_timeout");
    check("timeout_latency", stat_cyc - done_cyc, 17);
`endif

    check("rd_rst_overlap", viol, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
